// File: rtl/wb_port_arbiter.sv
// ============================================================================
//  Module   : wb_port_arbiter (plus riscv_pkg)
//  Purpose  : Register-file write-port arbiter. It shares one write port
//             between the pipeline writeback and a one-entry holding buffer
//             for long-latency (MDU) results. A forced grant bounds how long
//             the held result can starve.
//  Option   : define WB_ARB_PERF_EN to add the perf_conflict_cnt output
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_pkg;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
endpackage

module wb_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4   // 1..15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pipe_reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] pipe_rd_addr,
    input  logic [XLEN-1:0]           pipe_write_data,
    input  logic                      lu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] lu_rd_addr,
    input  logic [XLEN-1:0]           lu_data,
    output logic                      lu_ready,
    output logic                      rf_we,
    output logic [REG_ADDR_WIDTH-1:0] rf_rd_addr,
    output logic [XLEN-1:0]           rf_write_data,
    output logic                      pipe_stall,
    output logic                      lu_pending
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]               perf_conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HELD  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    // Counter value at which one more denial escalates to a forced grant.
    localparam logic [3:0] LIMIT_M1 = 4'(STARVE_LIMIT - 1);

    state_t                    state_q,    state_d;
    logic [3:0]                wait_cnt_q, wait_cnt_d;
    logic [REG_ADDR_WIDTH-1:0] buf_rd_q,   buf_rd_d;
    logic [XLEN-1:0]           buf_data_q, buf_data_d;

    // Writes to x0 are architecturally dead, so they never claim the port.
    logic pipe_valid;
    assign pipe_valid = pipe_reg_write && (pipe_rd_addr != '0);

    // State, wait counter and buffer registers; reset discards any held result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            wait_cnt_q <= '0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
        end
    end

    // Grant selection, write-port muxing and next-state logic.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        buf_rd_d      = buf_rd_q;
        buf_data_d    = buf_data_q;
        rf_we         = 1'b0;
        rf_rd_addr    = '0;
        rf_write_data = '0;
        pipe_stall    = 1'b0;
        lu_ready      = (state_q == ST_EMPTY);
        lu_pending    = (state_q != ST_EMPTY);

        case (state_q)
            ST_EMPTY: begin
                if (pipe_valid) begin
                    rf_we         = 1'b1;
                    rf_rd_addr    = pipe_rd_addr;
                    rf_write_data = pipe_write_data;
                end
                // A result for x0 is accepted and dropped without occupying the buffer.
                if (lu_valid && (lu_rd_addr != '0)) begin
                    buf_rd_d   = lu_rd_addr;
                    buf_data_d = lu_data;
                    wait_cnt_d = '0;
                    state_d    = ST_HELD;
                end
            end

            ST_HELD: begin
                if (pipe_valid) begin
                    rf_we         = 1'b1;
                    rf_rd_addr    = pipe_rd_addr;
                    rf_write_data = pipe_write_data;
                    if (pipe_rd_addr == buf_rd_q) begin
                        // Younger pipeline write supersedes the held result.
                        state_d    = ST_EMPTY;
                        wait_cnt_d = '0;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 4'd1;
                        if (wait_cnt_q == LIMIT_M1) begin
                            state_d = ST_FORCE;
                        end
                    end
                end else begin
                    rf_we         = 1'b1;
                    rf_rd_addr    = buf_rd_q;
                    rf_write_data = buf_data_q;
                    state_d       = ST_EMPTY;
                    wait_cnt_d    = '0;
                end
            end

            ST_FORCE: begin
                rf_we         = 1'b1;
                rf_rd_addr    = buf_rd_q;
                rf_write_data = buf_data_q;
                pipe_stall    = pipe_reg_write;
                state_d       = ST_EMPTY;
                wait_cnt_d    = '0;
            end

            default: begin
                state_d    = ST_EMPTY;
                wait_cnt_d = '0;
            end
        endcase
    end

`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_cnt_q;

    // Counts cycles where a held result lost the port to the pipeline.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cnt_q <= '0;
        end else if ((state_q == ST_HELD) && pipe_valid) begin
            perf_cnt_q <= perf_cnt_q + 32'd1;
        end
    end

    assign perf_conflict_cnt = perf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
// ============================================================================
//  Module   : tb_wb_port_arbiter
//  Purpose  : Directed self-checking bench for wb_port_arbiter
//             (STARVE_LIMIT = 4). Perf counter checked when WB_ARB_PERF_EN
//             is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_port_arbiter;

    logic        clk;
    logic        reset;
    logic        pipe_reg_write;
    logic [4:0]  pipe_rd_addr;
    logic [31:0] pipe_write_data;
    logic        lu_valid;
    logic [4:0]  lu_rd_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_write_data;
    logic        pipe_stall;
    logic        lu_pending;
`ifdef WB_ARB_PERF_EN
    logic [31:0] perf_conflict_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .pipe_reg_write  (pipe_reg_write),
        .pipe_rd_addr    (pipe_rd_addr),
        .pipe_write_data (pipe_write_data),
        .lu_valid        (lu_valid),
        .lu_rd_addr      (lu_rd_addr),
        .lu_data         (lu_data),
        .lu_ready        (lu_ready),
        .rf_we           (rf_we),
        .rf_rd_addr      (rf_rd_addr),
        .rf_write_data   (rf_write_data),
        .pipe_stall      (pipe_stall),
        .lu_pending      (lu_pending)
`ifdef WB_ARB_PERF_EN
        ,
        .perf_conflict_cnt (perf_conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked 2 units later.
    task automatic drive(input logic pw, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        pipe_reg_write  = pw;
        pipe_rd_addr    = pa;
        pipe_write_data = pd;
        lu_valid        = lv;
        lu_rd_addr      = la;
        lu_data         = ld;
        #2;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_rf(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".we"},   64'(rf_we),         64'(we));
        chk({tag, ".addr"}, 64'(rf_rd_addr),    64'(a));
        chk({tag, ".data"}, 64'(rf_write_data), 64'(d));
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Reset state
        chk("rst.lu_ready",   64'(lu_ready),   64'd1);
        chk("rst.lu_pending", 64'(lu_pending), 64'd0);
        chk("rst.pipe_stall", 64'(pipe_stall), 64'd0);
        chk_rf("rst", 1'b0, 5'd0, 32'h0);
        next_cycle();
        next_cycle();
        reset = 1'b0;
        next_cycle();

        // Idle pipe: LU result rd=5 written the following cycle
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'hDEADBEEF);
        chk("s1.ready", 64'(lu_ready), 64'd1);
        chk_rf("s1.c0", 1'b0, 5'd0, 32'h0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("s1.pending", 64'(lu_pending), 64'd1);
        chk("s1.notready", 64'(lu_ready), 64'd0);
        chk_rf("s1.c1", 1'b1, 5'd5, 32'hDEADBEEF);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("s1.ready2", 64'(lu_ready), 64'd1);
        chk("s1.pending2", 64'(lu_pending), 64'd0);
        chk_rf("s1.c2", 1'b0, 5'd0, 32'h0);
        next_cycle();

        // Starvation: rd=7 held, pipe hammers rd=3
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h00000077);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 32'h0);
            chk("s2.grant.stall", 64'(pipe_stall), 64'd0);
            chk("s2.grant.pend",  64'(lu_pending), 64'd1);
            chk_rf("s2.grant", 1'b1, 5'd3, 32'h00000033);
            next_cycle();
        end
        drive(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 32'h0);
        chk("s2.force.stall", 64'(pipe_stall), 64'd1);
        chk_rf("s2.force", 1'b1, 5'd7, 32'h00000077);
        next_cycle();
        drive(1'b1, 5'd3, 32'h00000033, 1'b0, 5'd0, 32'h0);
        chk("s2.after.stall", 64'(pipe_stall), 64'd0);
        chk("s2.after.pend",  64'(lu_pending), 64'd0);
        chk_rf("s2.after", 1'b1, 5'd3, 32'h00000033);
`ifdef WB_ARB_PERF_EN
        chk("s2.perf", 64'(perf_conflict_cnt), 64'd4);
`endif
        next_cycle();

        // Squash: rd=9 held, younger pipe write to rd=9 wins
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000099);
        next_cycle();
        drive(1'b1, 5'd9, 32'h00000011, 1'b0, 5'd0, 32'h0);
        chk_rf("s3.pipe", 1'b1, 5'd9, 32'h00000011);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("s3.pend", 64'(lu_pending), 64'd0);
        chk_rf("s3.none", 1'b0, 5'd0, 32'h0);
        next_cycle();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk_rf("s3.none2", 1'b0, 5'd0, 32'h0);
        next_cycle();

        // x0 handling: LU result to x0 dropped; pipe write to x0 not forwarded
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h12345678);
        chk("s4.ready", 64'(lu_ready), 64'd1);
        next_cycle();
        drive(1'b1, 5'd0, 32'hCAFEF00D, 1'b0, 5'd0, 32'h0);
        chk("s4.pend", 64'(lu_pending), 64'd0);
        chk("s4.ready2", 64'(lu_ready), 64'd1);
        chk_rf("s4.x0", 1'b0, 5'd0, 32'h0);
        next_cycle();

        // Reset while in FORCE
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h000000AA);
        next_cycle();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd3, 32'h00000044, 1'b0, 5'd0, 32'h0);
            next_cycle();
        end
        drive(1'b1, 5'd3, 32'h00000044, 1'b0, 5'd0, 32'h0);
        chk("s5.force.stall", 64'(pipe_stall), 64'd1);
        chk_rf("s5.force", 1'b1, 5'd7, 32'h000000AA);
        reset = 1'b1;
        #1;
        chk("s5.rst.stall", 64'(pipe_stall), 64'd0);
        chk("s5.rst.pend",  64'(lu_pending), 64'd0);
        chk("s5.rst.ready", 64'(lu_ready),   64'd1);
        chk_rf("s5.rst.pipe", 1'b1, 5'd3, 32'h00000044);
`ifdef WB_ARB_PERF_EN
        chk("s5.perf", 64'(perf_conflict_cnt), 64'd0);
`endif
        next_cycle();
        reset = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk_rf("s5.post", 1'b0, 5'd0, 32'h0);
            chk("s5.post.pend", 64'(lu_pending), 64'd0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
